// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clock/reset sequencer.
// State enum, default timing constants and the counter width helper.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        PULSE,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_STABLE_CYCLES       = 1024;
    localparam int DEF_MAX_RETRIES         = 3;

    // Width of a down-counter that must hold (max of a, b, c) - 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/clock_reset_controller.sv
// MMCM reset/lock sequencer: pulses mmcm_reset, waits for lock with
// timeout and retries, requires a stable lock, then releases sys_rst.
// Ports: clk, rst_n, locked (async), reinit -> mmcm_reset, sys_rst,
// ready, fault, retry_cnt; lock_lost when CLK_CTRL_LOCK_LOSS_EN is set.
module clock_reset_controller
    import clk_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               locked,
    input  logic                               reinit,
    output logic                               mmcm_reset,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fault,
`ifdef CLK_CTRL_LOCK_LOSS_EN
    output logic                               lock_lost,
`endif
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

    localparam int CW = cnt_width(RST_PULSE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES,
                                  STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] C_PULSE  = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] C_TOUT   = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] C_MAXR   = RW'(MAX_RETRIES);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [RW-1:0]   r_retry;
    logic [RW-1:0]   w_retry_nxt;
    logic            w_locked_s;
    logic            r_mmcm_reset;
    logic            r_sys_rst;
    logic            r_ready;
    logic            r_fault;
`ifdef CLK_CTRL_LOCK_LOSS_EN
    logic            w_lost;
    logic            r_lock_lost;
`endif

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (w_locked_s)
    );

    always_comb begin
        w_next      = r_state;
        w_retry_nxt = r_retry;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
`ifdef CLK_CTRL_LOCK_LOSS_EN
        w_lost      = 1'b0;
`endif
        if (reinit) begin
            w_next      = PULSE;
            w_retry_nxt = '0;
        end else begin
            unique case (r_state)
                PULSE: begin
                    if (r_cnt == '0) w_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_next = STABLE;
                    end else if (r_cnt == '0) begin
                        if (r_retry < C_MAXR) begin
                            w_retry_nxt = r_retry + RW'(1);
                            w_next      = PULSE;
                        end else begin
                            w_next = FAULT;
                        end
                    end
                end
                STABLE: begin
                    // A dropout restarts the window without a retry.
                    if (!w_locked_s)       w_cnt_nxt = C_STABLE;
                    else if (r_cnt == '0)  w_next    = RUN;
                end
                RUN: begin
`ifdef CLK_CTRL_LOCK_LOSS_EN
                    if (!w_locked_s) begin
                        w_next      = PULSE;
                        w_retry_nxt = '0;
                        w_lost      = 1'b1;
                    end
`endif
                end
                FAULT: begin
                end
                default: w_next = PULSE;
            endcase
        end
        // Counter reloads on every entry, including PULSE re-entry.
        if (reinit || (w_next != r_state)) begin
            unique case (w_next)
                PULSE:     w_cnt_nxt = C_PULSE;
                WAIT_LOCK: w_cnt_nxt = C_TOUT;
                STABLE:    w_cnt_nxt = C_STABLE;
                default:   w_cnt_nxt = '0;
            endcase
        end
    end

    // Outputs are registered from the next state so they track r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PULSE;
            r_cnt        <= C_PULSE;
            r_retry      <= '0;
            r_mmcm_reset <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_mmcm_reset <= (w_next == PULSE);
            r_sys_rst    <= (w_next != RUN);
            r_ready      <= (w_next == RUN);
            r_fault      <= (w_next == FAULT);
        end
    end

`ifdef CLK_CTRL_LOCK_LOSS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_lock_lost <= 1'b0;
        else if (w_lost) r_lock_lost <= 1'b1;
    end

    assign lock_lost = r_lock_lost;
`endif

    assign mmcm_reset = r_mmcm_reset;
    assign sys_rst    = r_sys_rst;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_clock_reset_controller.sv
// Bench for clock_reset_controller: predicted output-change events are
// queued by the stimulus and matched by a negedge monitor.
module tb_clock_reset_controller;

    localparam int P  = 4;
    localparam int TO = 32;
    localparam int S  = 8;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       reinit;
    logic       mmcm_reset;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
`ifdef CLK_CTRL_LOCK_LOSS_EN
    logic       lock_lost;
`endif

    typedef struct {
        int         c;
        logic [5:0] v;
    } ev_t;

    ev_t        q[$];
    ev_t        e;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 0;
    logic [5:0] prev = '0;
    logic [5:0] cur;

    clock_reset_controller #(
        .RST_PULSE_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES (TO),
        .STABLE_CYCLES       (S),
        .MAX_RETRIES         (MR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .reinit     (reinit),
        .mmcm_reset (mmcm_reset),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
`ifdef CLK_CTRL_LOCK_LOSS_EN
        .lock_lost  (lock_lost),
`endif
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cur = {mmcm_reset, sys_rst, ready, fault, retry_cnt};
        if (mon_en && cur !== prev) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected: cyc=%0d out=%b, required no change",
                         cyc, cur);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.v !== cur) begin
                    bad++;
                    $display("FAIL event: cyc=%0d out=%b, required cyc=%0d out=%b",
                             cyc, cur, e.c, e.v);
                end
            end
        end
        prev = cur;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] mk(input logic m, input logic s,
                                      input logic r, input logic f,
                                      input int rc);
        return {m, s, r, f, rc[1:0]};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [5:0] v);
        ev_t x;
        x.c = c;
        x.v = v;
        q.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d events pending at cyc=%0d, required 0",
                     q.size(), cyc);
            q.delete();
        end
    endtask

    // From a pulse start at cycle r: lock after a random delay, expect
    // the pulse to end after P cycles and ready after sync + S cycles.
    task automatic run_seq(input int r, input bit glitch);
        int d;
        int t;
        int g;
        d = $urandom_range(5, 20);
        push(r + P, mk(0, 1, 0, 0, 0));
        while (cyc < r + d) step();
        locked = 1'b1;
        t = cyc;
        if (!glitch) begin
            push(t + 3 + S, mk(0, 0, 1, 0, 0));
        end else begin
            g = $urandom_range(0, 5);
            while (cyc < t + 3 + g) step();
            locked = 1'b0;
            step();
            locked = 1'b1;
            push(cyc + 2 + S, mk(0, 0, 1, 0, 0));
        end
        wait_drain(200);
    endtask

    task automatic do_reinit(input bit drop, output int r);
        step();
        reinit = 1'b1;
        if (drop) locked = 1'b0;
        push(cyc + 1, mk(1, 1, 0, 0, 0));
        step();
        reinit = 1'b0;
        r = cyc;
    endtask

    initial begin
        int r;
        int rk;
        int l;
        rst_n  = 1'b0;
        locked = 1'b0;
        reinit = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_mmcm", int'(mmcm_reset), 1);
        chk("rst_sys", int'(sys_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_retry", int'(retry_cnt), 0);

        // Nominal lock after release.
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run_seq(cyc, 1'b0);
        chk("nom_retry", int'(retry_cnt), 0);

`ifdef CLK_CTRL_LOCK_LOSS_EN
        chk("ll_before", int'(lock_lost), 0);
        step();
        locked = 1'b0;
        l = cyc;
        push(l + 3, mk(1, 1, 0, 0, 0));
        while (cyc < l + 3) step();
        run_seq(cyc, 1'b0);
        chk("ll_after", int'(lock_lost), 1);
`else
        step();
        locked = 1'b0;
        repeat (20) step();
        chk("run_hold_ready", int'(ready), 1);
        chk("run_hold_sys", int'(sys_rst), 0);
        locked = 1'b1;
        repeat (3) step();
`endif

        // Glitchy lock during STABLE.
        do_reinit(1'b1, r);
        run_seq(r, 1'b1);
        chk("glitch_retry", int'(retry_cnt), 0);

        // Lock never arrives: retries, then FAULT.
        do_reinit(1'b1, r);
        for (int k = 0; k <= MR; k++) begin
            rk = r + k * (P + TO);
            push(rk + P, mk(0, 1, 0, 0, k));
            if (k < MR)
                push(rk + P + TO, mk(1, 1, 0, 0, k + 1));
            else
                push(rk + P + TO, mk(0, 1, 0, 1, k));
        end
        wait_drain(300);
        chk("flt_fault", int'(fault), 1);
        chk("flt_sys", int'(sys_rst), 1);
        chk("flt_retry", int'(retry_cnt), MR);
        repeat (40) step();
        chk("flt_hold", int'(fault), 1);

        // Recovery from FAULT via reinit.
        do_reinit(1'b0, r);
        chk("rec_fault", int'(fault), 0);
        chk("rec_mmcm", int'(mmcm_reset), 1);
        chk("rec_retry", int'(retry_cnt), 0);
        run_seq(r, 1'b0);

        // Async reset in the middle of STABLE.
        do_reinit(1'b1, r);
        push(r + P, mk(0, 1, 0, 0, 0));
        while (cyc < r + 6) step();
        locked = 1'b1;
        l = cyc;
        wait_drain(50);
        while (cyc < l + 5) step();
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_mmcm", int'(mmcm_reset), 1);
        chk("mid_sys", int'(sys_rst), 1);
        chk("mid_ready", int'(ready), 0);
        chk("mid_fault", int'(fault), 0);
        chk("mid_retry", int'(retry_cnt), 0);
`ifdef CLK_CTRL_LOCK_LOSS_EN
        chk("mid_lost", int'(lock_lost), 0);
`endif
        locked = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run_seq(cyc, 1'b0);

        wait_drain(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_reset_controller.md
# clock_reset_controller

Sequences the `clock_generator` MMCM from the board clock domain. Issues a bounded-width MMCM reset pulse, waits for `locked` with a timeout and retry budget, and requires a stable-lock interval before releasing the system reset. Monitors lock afterwards. It sits between the top-level board reset and every 65 MHz-domain consumer, and is the single owner of the `clock_generator` `reset` input.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: MMCM reset assertion width in `clk` cycles (min 1).
- `LOCK_TIMEOUT_CYCLES`, 65536: max cycles in WAIT_LOCK before a retry.
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release.
- `MAX_RETRIES`, 3: reset attempts after the first before FAULT.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: board clock, also the MMCM input clock.
- `rst_n`  in  1: async active-low reset.
- `locked`  in  1: MMCM lock, asynchronous to `clk`.
- `reinit`  in  1: single-cycle request to re-run the sequence.
- `mmcm_reset`  out  1: drives `clock_generator.reset`, active-high.
- `sys_rst`  out  1: active-high reset for downstream logic.
- `ready`  out  1: high only in RUN.
- `fault`  out  1: high only in FAULT.
- `retry_cnt`  out  $clog2(MAX_RETRIES+1): attempts used so far.

## Operation
- `locked` passes through a 2-FF synchronizer, producing `locked_s`. All decisions use `locked_s`.
- States and transitions:
  - PULSE: `mmcm_reset`=1. After `RST_PULSE_CYCLES` cycles, go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK: `mmcm_reset`=0.
    - `locked_s`=1: go to STABLE.
    - Counter reaches `LOCK_TIMEOUT_CYCLES`-1: if `retry_cnt`<`MAX_RETRIES`, increment `retry_cnt` and go to PULSE; otherwise go to FAULT.
  - STABLE: counts consecutive `locked_s`=1 cycles.
    - `locked_s`=0: restart the count and stay in STABLE. Does not consume a retry.
    - Count reaches `STABLE_CYCLES`-1: go to RUN.
  - RUN: `sys_rst`=0, `ready`=1.
  - FAULT: `mmcm_reset`=0, `sys_rst`=1, `fault`=1. Only `reinit` or `rst_n` leaves this state.
- `sys_rst`=1 in every state except RUN.
- `reinit`: accepted in any state. Goes to PULSE, clears `retry_cnt`, clears the counter. `reinit` takes priority over every other transition in the same cycle.
- One shared down-counter, sized to the maximum of the three cycle parameters. It is reloaded on every state entry.

## Timing
- Reset values: `mmcm_reset`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0. State is PULSE with the counter loaded.
- All outputs are registered.
- `mmcm_reset` is high for exactly `RST_PULSE_CYCLES` cycles after `rst_n` deassertion.
- `locked` rising edge to the STABLE transition: 3 cycles (2 sync + 1 state register).
- Entry to STABLE to the `ready` rise: `STABLE_CYCLES` cycles, provided `locked_s` stays high.
- `reinit` sampled at edge N: `mmcm_reset`=1 and `ready`=0 at N+1.
- `rst_n` assertion forces the reset values immediately, mid-sequence included. Release is synchronous to `clk` through the normal PULSE path.

## Configuration
- `CLK_CTRL_LOCK_LOSS_EN` defined:
  - In RUN, `locked_s`=0 for 1 cycle asserts `sys_rst` and `ready`=0 on the next edge.
  - The FSM goes to PULSE with `retry_cnt` cleared.
  - A sticky `lock_lost` output port is added, cleared only by `rst_n`.
- Not defined: RUN ignores `locked_s`, and the `lock_lost` port is absent.

## Structure
- Package `clk_ctrl_pkg` contains:
  - the state enum (PULSE, WAIT_LOCK, STABLE, RUN, FAULT);
  - the counter-width function;
  - default parameter constants.
- Sub-module `sync_2ff`: generic single-bit 2-flop synchronizer with async active-low reset to 0. Instantiated once, for `locked`.

## Test plan
All scenarios use `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- Nominal lock: `rst_n` low to high, `locked` rises 10 cycles later.
  - Required: `mmcm_reset` high for exactly 4 cycles.
  - Required: `ready` rises 3+8 cycles after `locked` rises; `retry_cnt`=0.
- Glitchy lock: `locked` drops for 1 cycle at the 5th cycle of STABLE.
  - Required: stable count restarts; `ready` rises 8 cycles after re-lock plus sync latency; no retry consumed.
- Lock never arrives: `locked` held at 0.
  - Required: three PULSE/WAIT_LOCK cycles, `retry_cnt` steps 0→1→2, then `fault`=1 and `sys_rst`=1.
- Recovery from FAULT: `reinit` pulse while in FAULT.
  - Required: `fault`=0 and `mmcm_reset`=1 next cycle; `retry_cnt`=0.
- Reset mid-STABLE: assert `rst_n` low.
  - Required: all outputs take their reset values without waiting for a clock edge.
- Lock loss in RUN, `CLK_CTRL_LOCK_LOSS_EN` defined: drop `locked` during RUN.
  - Required: `ready`=0 3 cycles later, `lock_lost`=1, re-sequence runs.
  - Required with the macro undefined: `ready` stays 1.
